// File: rtl/axi_pkg.sv
// axi_pkg: shared state encoding and response codes for the AXI initiator
package axi_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WR_REQ,
        WR_RESP,
        RD_REQ,
        RD_DATA,
        RSP
    } axi_m_state_t;

    localparam logic [1:0] RSP_OK      = 2'b00;
    localparam logic [1:0] RSP_SLVERR  = 2'b01;
    localparam logic [1:0] RSP_IDERR   = 2'b10;
    localparam logic [1:0] RSP_TIMEOUT = 2'b11;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

endpackage

// File: rtl/axi_watchdog.sv
// axi_watchdog: counts cycles spent waiting on the slave and flags expiry
module axi_watchdog #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic areset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;

    logic [CW-1:0] cnt;

    // expired fires on the TIMEOUT-th consecutive waiting cycle; TIMEOUT=0 never fires
    assign expired = (TIMEOUT != 0) && enable && (int'(cnt) == TIMEOUT - 1);

    // wait-cycle counter, restarted on every handshake or when not waiting
    always_ff @(posedge clk or negedge areset) begin
        if (!areset)
            cnt <= '0;
        else if (clear)
            cnt <= '0;
        else if (enable && !expired)
            cnt <= cnt + 1'b1;
    end

endmodule

// File: rtl/axi_master_ctrl.sv
// axi_master_ctrl: single-outstanding AXI initiator driven by a command/response port
module axi_master_ctrl
    import axi_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int ID_W    = 4,
    parameter int TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  areset,
    input  logic                  cmd_valid_i,
    output logic                  cmd_ready_o,
    input  logic                  cmd_write_i,
    input  logic [ADDR_W-1:0]     cmd_addr_i,
    input  logic [DATA_W-1:0]     cmd_wdata_i,
    input  logic [DATA_W/8-1:0]   cmd_wstrb_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [DATA_W-1:0]     rsp_rdata_o,
    output logic [1:0]            rsp_status_o,
    output logic [ID_W-1:0]       awid_o,
    output logic [ADDR_W-1:0]     awaddr_o,
    output logic                  awvalid_o,
    input  logic                  awready_i,
    output logic [ID_W-1:0]       wid_o,
    output logic [DATA_W-1:0]     wdata_o,
    output logic [DATA_W/8-1:0]   wstrb_o,
    output logic                  wlast_o,
    output logic                  wvalid_o,
    input  logic                  wready_i,
    input  logic [ID_W-1:0]       bid_i,
    input  logic [1:0]            bresp_i,
    input  logic                  bvalid_i,
    output logic                  bready_o,
    output logic [ID_W-1:0]       arid_o,
    output logic [ADDR_W-1:0]     araddr_o,
    output logic                  arvalid_o,
    input  logic                  arready_i,
    input  logic [ID_W-1:0]       rid_i,
    input  logic [DATA_W-1:0]     rdata_i,
    input  logic [DATA_W/8-1:0]   rstrb_i,
    input  logic                  rlast_i,
    input  logic                  rvalid_i,
    output logic                  rready_o
);

    axi_m_state_t    state, state_nx;
    logic [ID_W-1:0] id;
    logic            aw_done, w_done;
    logic            aw_hs, w_hs, b_hs, ar_hs, r_hs, any_hs;
    logic            wait_st, expired, abort;
    logic            unused_r;

    // single beat only: the strobe and last flag on R carry no information here
    assign unused_r = ^{rstrb_i, rlast_i};

    assign cmd_ready_o = state == IDLE;
    assign rsp_valid_o = state == RSP;
    assign awvalid_o   = (state == WR_REQ) && !aw_done;
    assign wvalid_o    = (state == WR_REQ) && !w_done;
    assign bready_o    = state == WR_RESP;
    assign arvalid_o   = state == RD_REQ;
    assign rready_o    = state == RD_DATA;
    assign wlast_o     = 1'b1;
    assign awid_o      = id;
    assign wid_o       = id;
    assign arid_o      = id;

    assign aw_hs   = awvalid_o && awready_i;
    assign w_hs    = wvalid_o && wready_i;
    assign b_hs    = bready_o && bvalid_i;
    assign ar_hs   = arvalid_o && arready_i;
    assign r_hs    = rready_o && rvalid_i;
    assign any_hs  = aw_hs || w_hs || b_hs || ar_hs || r_hs;
    assign wait_st = state inside {WR_REQ, WR_RESP, RD_REQ, RD_DATA};
    assign abort   = expired && !any_hs;

    axi_watchdog #(.TIMEOUT(TIMEOUT)) u_wdog (
        .clk     (clk),
        .areset  (areset),
        .clear   (!wait_st || any_hs),
        .enable  (wait_st),
        .expired (expired)
    );

    // state register
    always_ff @(posedge clk or negedge areset) begin
        if (!areset)
            state <= IDLE;
        else
            state <= state_nx;
    end

    // next-state logic; a handshake in the same cycle as expiry wins over the abort
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (cmd_valid_i) state_nx = cmd_write_i ? WR_REQ : RD_REQ;
            WR_REQ:  state_nx = ((aw_done || aw_hs) && (w_done || w_hs)) ? WR_RESP : abort ? RSP : WR_REQ;
            WR_RESP: if (b_hs || abort) state_nx = RSP;
            RD_REQ:  state_nx = ar_hs ? RD_DATA : abort ? RSP : RD_REQ;
            RD_DATA: if (r_hs || abort) state_nx = RSP;
            RSP:     if (rsp_ready_i) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // command capture, per-channel handshake tracking, response capture and ID counter
    always_ff @(posedge clk or negedge areset) begin
        if (!areset) begin
            awaddr_o     <= '0;
            wdata_o      <= '0;
            wstrb_o      <= '0;
            araddr_o     <= '0;
            aw_done      <= 1'b0;
            w_done       <= 1'b0;
            rsp_rdata_o  <= '0;
            rsp_status_o <= RSP_OK;
            id           <= '0;
        end else begin
            if (state == IDLE && cmd_valid_i) begin
                if (cmd_write_i) begin
                    awaddr_o <= cmd_addr_i;
                    wdata_o  <= cmd_wdata_i;
                    wstrb_o  <= cmd_wstrb_i;
                end else begin
                    araddr_o <= cmd_addr_i;
                end
            end
            aw_done <= (state == WR_REQ) && (aw_done || aw_hs);
            w_done  <= (state == WR_REQ) && (w_done || w_hs);
            if (b_hs) begin
                rsp_rdata_o  <= '0;
                rsp_status_o <= bid_i != id ? RSP_IDERR : bresp_i != OKAY ? RSP_SLVERR : RSP_OK;
            end else if (r_hs) begin
                rsp_rdata_o  <= rdata_i;
                rsp_status_o <= rid_i != id ? RSP_IDERR : RSP_OK;
            end else if (abort) begin
                rsp_rdata_o  <= '0;
                rsp_status_o <= RSP_TIMEOUT;
            end
            if (state == RSP && rsp_ready_i)
                id <= id + 1'b1;
        end
    end

endmodule

// File: tb/tb_axi_master_ctrl.sv
// tb_axi_master_ctrl: randomized bench with a behavioural slave and a memory/ID reference model
module tb_axi_master_ctrl;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int IW = 4;
    localparam int SW = DW / 8;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          areset = 1'b0;
    logic          cmd_valid_i, cmd_ready_o, cmd_write_i;
    logic [AW-1:0] cmd_addr_i;
    logic [DW-1:0] cmd_wdata_i;
    logic [SW-1:0] cmd_wstrb_i;
    logic          rsp_valid_o, rsp_ready_i;
    logic [DW-1:0] rsp_rdata_o;
    logic [1:0]    rsp_status_o;
    logic [IW-1:0] awid_o, wid_o, arid_o, bid_i, rid_i;
    logic [AW-1:0] awaddr_o, araddr_o;
    logic [DW-1:0] wdata_o, rdata_i;
    logic [SW-1:0] wstrb_o, rstrb_i;
    logic          awvalid_o, awready_i, wlast_o, wvalid_o, wready_i;
    logic [1:0]    bresp_i;
    logic          bvalid_i, bready_o, arvalid_o, arready_i, rlast_i, rvalid_i, rready_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    axi_master_ctrl #(.ADDR_W(AW), .DATA_W(DW), .ID_W(IW), .TIMEOUT(TO)) dut (
        .clk(clk), .areset(areset),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_write_i(cmd_write_i),
        .cmd_addr_i(cmd_addr_i), .cmd_wdata_i(cmd_wdata_i), .cmd_wstrb_i(cmd_wstrb_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_rdata_o(rsp_rdata_o),
        .rsp_status_o(rsp_status_o),
        .awid_o(awid_o), .awaddr_o(awaddr_o), .awvalid_o(awvalid_o), .awready_i(awready_i),
        .wid_o(wid_o), .wdata_o(wdata_o), .wstrb_o(wstrb_o), .wlast_o(wlast_o),
        .wvalid_o(wvalid_o), .wready_i(wready_i),
        .bid_i(bid_i), .bresp_i(bresp_i), .bvalid_i(bvalid_i), .bready_o(bready_o),
        .arid_o(arid_o), .araddr_o(araddr_o), .arvalid_o(arvalid_o), .arready_i(arready_i),
        .rid_i(rid_i), .rdata_i(rdata_i), .rstrb_i(rstrb_i), .rlast_i(rlast_i),
        .rvalid_i(rvalid_i), .rready_o(rready_o)
    );

    // slave configuration (written by the main sequence only)
    int            aw_d, w_d, ar_d, b_d, r_d;
    logic [1:0]    s_bresp;
    logic [IW-1:0] s_xor;
    bit            s_clr = 1'b0;

    // slave observations
    logic [AW-1:0] s_awaddr, s_araddr;
    logic [DW-1:0] s_wdata, w_prev, sv;
    logic [SW-1:0] s_wstrb;
    logic [IW-1:0] s_awid, s_wid, s_arid;
    bit            got_aw, got_w, got_ar, b_fire, r_fire, b_done, r_done;
    bit            w_unstable, bready_early, wrote;
    int            aw_c, w_c, ar_c, b_c, r_c, aw_hi, w_hi, ar_hi;
    logic [DW-1:0] smem [logic [AW-1:0]];

    // reference model state
    logic [DW-1:0] mem_m [logic [AW-1:0]];
    int unsigned   exp_id = 0;

    // behavioural slave: decides handshakes at the falling edge, they complete at the next rising edge
    initial begin
        {awready_i, wready_i, arready_i, bvalid_i, rvalid_i, rlast_i} = '0;
        bid_i = '0; bresp_i = '0; rid_i = '0; rdata_i = '0; rstrb_i = '0;
        forever begin
            @(negedge clk);
            if (s_clr || !areset) begin
                {awready_i, wready_i, arready_i, bvalid_i, rvalid_i} = '0;
                {got_aw, got_w, got_ar, b_fire, r_fire, b_done, r_done} = '0;
                {w_unstable, bready_early, wrote} = '0;
                aw_c = 0; w_c = 0; ar_c = 0; b_c = 0; r_c = 0;
                aw_hi = 0; w_hi = 0; ar_hi = 0;
            end else begin
                if (bready_o && !(got_aw && got_w)) bready_early = 1'b1;
                if (b_fire) begin
                    bvalid_i = 1'b0; b_fire = 1'b0; b_done = 1'b1;
                end else if (got_aw && got_w && !b_done) begin
                    if (b_c >= b_d) begin
                        bvalid_i = 1'b1; bid_i = s_awid ^ s_xor; bresp_i = s_bresp;
                    end
                    b_c++;
                    b_fire = bvalid_i && bready_o;
                end
                if (r_fire) begin
                    rvalid_i = 1'b0; r_fire = 1'b0; r_done = 1'b1;
                end else if (got_ar && !r_done) begin
                    if (r_c >= r_d) begin
                        rvalid_i = 1'b1; rid_i = s_arid ^ s_xor; rlast_i = 1'b1; rstrb_i = '1;
                        rdata_i = smem.exists(s_araddr) ? smem[s_araddr] : '0;
                    end
                    r_c++;
                    r_fire = rvalid_i && rready_o;
                end
                if (awvalid_o) aw_hi++;
                awready_i = awvalid_o && !got_aw && aw_c >= aw_d;
                if (awvalid_o && !got_aw) aw_c++;
                if (awready_i) begin got_aw = 1'b1; s_awaddr = awaddr_o; s_awid = awid_o; end
                if (wvalid_o) begin
                    if (w_hi > 0 && wdata_o !== w_prev) w_unstable = 1'b1;
                    w_prev = wdata_o;
                    w_hi++;
                end
                wready_i = wvalid_o && !got_w && w_c >= w_d;
                if (wvalid_o && !got_w) w_c++;
                if (wready_i) begin got_w = 1'b1; s_wdata = wdata_o; s_wstrb = wstrb_o; s_wid = wid_o; end
                if (got_aw && got_w && !wrote) begin
                    wrote = 1'b1;
                    sv = smem.exists(s_awaddr) ? smem[s_awaddr] : '0;
                    for (int i = 0; i < SW; i++) if (s_wstrb[i]) sv[8*i +: 8] = s_wdata[8*i +: 8];
                    smem[s_awaddr] = sv;
                end
                if (arvalid_o) ar_hi++;
                arready_i = arvalid_o && !got_ar && ar_c >= ar_d;
                if (arvalid_o && !got_ar) ar_c++;
                if (arready_i) begin got_ar = 1'b1; s_araddr = araddr_o; s_arid = arid_o; end
            end
        end
    end

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] nd,
                                            input logic [SW-1:0] st);
        logic [DW-1:0] m = '0;
        for (int i = 0; i < SW; i++) if (st[i]) m = m | (DW'(32'hFF) << (8 * i));
        return (old & ~m) | (nd & m);
    endfunction

    task automatic run_txn(input bit wr, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                           input logic [SW-1:0] strb, input int awd, input int wd, input int ard,
                           input int bd, input int rd, input logic [1:0] bresp,
                           input logic [IW-1:0] idx, input string tag);
        bit            to;
        logic [1:0]    est;
        logic [DW-1:0] erd, old;
        int            n;
        to  = !wr && ard >= TO;
        old = mem_m.exists(addr) ? mem_m[addr] : '0;
        est = to ? 2'b11 : (idx != 0) ? 2'b10 : (wr && bresp != 2'b00) ? 2'b01 : 2'b00;
        erd = (wr || to) ? '0 : old;
        @(negedge clk); #1;
        aw_d = awd; w_d = wd; ar_d = ard; b_d = bd; r_d = rd; s_bresp = bresp; s_xor = idx;
        s_clr = 1'b1;
        @(negedge clk); #1;
        s_clr = 1'b0;
        cmd_valid_i = 1'b1; cmd_write_i = wr; cmd_addr_i = addr; cmd_wdata_i = data; cmd_wstrb_i = strb;
        checks++;
        if (cmd_ready_o !== 1'b1) begin
            errors++; $display("FAIL %s cmd_ready_idle: got %b want 1", tag, cmd_ready_o);
        end
        @(negedge clk); #1;
        cmd_valid_i = 1'b0;
        checks++;
        if ({awvalid_o, wvalid_o, arvalid_o, cmd_ready_o} !== (wr ? 4'b1100 : 4'b0010)) begin
            errors++;
            $display("FAIL %s valid_latency: aw/w/ar/cmd_ready got %b%b%b%b want %b", tag,
                     awvalid_o, wvalid_o, arvalid_o, cmd_ready_o, wr ? 4'b1100 : 4'b0010);
        end
        n = 0;
        while (rsp_valid_o !== 1'b1 && n < 60) begin @(negedge clk); #1; n++; end
        checks++;
        if (n >= 60) begin errors++; $display("FAIL %s rsp_wait: no rsp_valid within 60 cycles", tag); end
        checks++;
        if (rsp_status_o !== est) begin
            errors++; $display("FAIL %s status: got %b want %b", tag, rsp_status_o, est);
        end
        checks++;
        if (rsp_rdata_o !== erd) begin
            errors++; $display("FAIL %s rdata: got %h want %h", tag, rsp_rdata_o, erd);
        end
        if (wr) begin
            checks++;
            if (s_awaddr !== addr || s_wdata !== data || s_wstrb !== strb) begin
                errors++;
                $display("FAIL %s aw_w_payload: got %h/%h/%h want %h/%h/%h", tag,
                         s_awaddr, s_wdata, s_wstrb, addr, data, strb);
            end
            checks++;
            if (s_awid !== IW'(exp_id) || s_wid !== IW'(exp_id)) begin
                errors++; $display("FAIL %s aw_w_id: got %h/%h want %h", tag, s_awid, s_wid, IW'(exp_id));
            end
            checks++;
            if (aw_hi != awd + 1 || w_hi != wd + 1 || w_unstable || bready_early) begin
                errors++;
                $display("FAIL %s aw_w_timing: awvalid %0d wvalid %0d cycles unstable %0b early_bready %0b want %0d %0d 0 0",
                         tag, aw_hi, w_hi, w_unstable, bready_early, awd + 1, wd + 1);
            end
        end else if (!to) begin
            checks++;
            if (s_araddr !== addr || s_arid !== IW'(exp_id) || ar_hi != ard + 1) begin
                errors++;
                $display("FAIL %s ar_chan: got addr %h id %h cycles %0d want %h %h %0d", tag,
                         s_araddr, s_arid, ar_hi, addr, IW'(exp_id), ard + 1);
            end
        end else begin
            checks++;
            if (ar_hi != TO || arvalid_o !== 1'b0 || rready_o !== 1'b0) begin
                errors++;
                $display("FAIL %s timeout_abort: arvalid cycles %0d arvalid %b rready %b want %0d 0 0",
                         tag, ar_hi, arvalid_o, rready_o, TO);
            end
        end
        repeat ($urandom_range(0, 2)) begin
            @(negedge clk); #1;
            checks++;
            if (rsp_valid_o !== 1'b1 || rsp_status_o !== est || rsp_rdata_o !== erd || cmd_ready_o !== 1'b0) begin
                errors++;
                $display("FAIL %s rsp_hold: valid %b status %b rdata %h cmd_ready %b want 1 %b %h 0",
                         tag, rsp_valid_o, rsp_status_o, rsp_rdata_o, cmd_ready_o, est, erd);
            end
        end
        rsp_ready_i = 1'b1;
        @(negedge clk); #1;
        rsp_ready_i = 1'b0;
        checks++;
        if (cmd_ready_o !== 1'b1 || rsp_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL %s rsp_release: cmd_ready %b rsp_valid %b want 1 0", tag, cmd_ready_o, rsp_valid_o);
        end
        if (wr) mem_m[addr] = merge(old, data, strb);
        exp_id = (exp_id + 1) % (1 << IW);
    endtask

    task automatic test_reset;
        #12;
        checks++;
        if (cmd_ready_o !== 1'b1 ||
            {awvalid_o, wvalid_o, arvalid_o, bready_o, rready_o, rsp_valid_o} !== 6'b0) begin
            errors++;
            $display("FAIL reset_ctrl: cmd_ready %b valids/readies %b want 1 000000", cmd_ready_o,
                     {awvalid_o, wvalid_o, arvalid_o, bready_o, rready_o, rsp_valid_o});
        end
        checks++;
        if ({rsp_rdata_o, rsp_status_o, awaddr_o, araddr_o, wdata_o, wstrb_o, awid_o, wid_o, arid_o} !== '0) begin
            errors++;
            $display("FAIL reset_data: rdata %h status %b awaddr %h araddr %h wdata %h wstrb %h ids %h %h %h want all 0",
                     rsp_rdata_o, rsp_status_o, awaddr_o, araddr_o, wdata_o, wstrb_o, awid_o, wid_o, arid_o);
        end
        @(negedge clk); #1;
        areset = 1'b1;
    endtask

    task automatic test_write_read;
        run_txn(1'b1, 32'd3, 32'hDEADBEEF, 4'hF, 0, 0, 0, 0, 0, 2'b00, '0, "wr_basic");
        run_txn(1'b0, 32'd3, '0, '0, 0, 0, 0, 0, 0, 2'b00, '0, "rd_basic");
    endtask

    task automatic test_errors;
        run_txn(1'b0, 32'd3, '0, '0, 0, 0, 1, 0, 2, 2'b00, 4'd7, "rd_iderr");
        run_txn(1'b1, 32'd8, 32'h12345678, 4'hF, 0, 3, 0, 0, 0, 2'b00, '0, "wr_wdelay");
        run_txn(1'b1, 32'd9, 32'hCAFEF00D, 4'h5, 2, 0, 0, 1, 0, 2'b10, '0, "wr_slverr");
    endtask

    task automatic test_timeout;
        run_txn(1'b0, 32'd3, '0, '0, 0, 0, 1000, 0, 0, 2'b00, '0, "rd_timeout");
    endtask

    task automatic test_random;
        for (int k = 0; k < 24; k++) begin
            bit wr = 1'(($urandom() % 2));
            run_txn(wr, AW'($urandom_range(0, 7)), $urandom(), SW'($urandom()),
                    $urandom_range(0, 3), $urandom_range(0, 3),
                    ($urandom() % 8 == 0) ? 1000 : $urandom_range(0, 3),
                    $urandom_range(0, 3), $urandom_range(0, 3),
                    ($urandom() % 5 == 0) ? 2'b10 : 2'b00,
                    ($urandom() % 6 == 0) ? IW'($urandom_range(1, 15)) : '0, "random");
        end
    endtask

    task automatic test_reset_mid;
        @(negedge clk); #1;
        aw_d = 5; w_d = 5; ar_d = 0; b_d = 0; r_d = 0; s_bresp = 2'b00; s_xor = '0;
        s_clr = 1'b1;
        @(negedge clk); #1;
        s_clr = 1'b0;
        cmd_valid_i = 1'b1; cmd_write_i = 1'b1; cmd_addr_i = 32'd5; cmd_wdata_i = 32'hA5A5A5A5; cmd_wstrb_i = 4'hF;
        @(negedge clk); #1;
        cmd_valid_i = 1'b0;
        @(negedge clk); #3;
        areset = 1'b0;
        #1;
        checks++;
        if ({awvalid_o, wvalid_o, arvalid_o, bready_o, rready_o, rsp_valid_o} !== 6'b0 ||
            cmd_ready_o !== 1'b1 || awid_o !== '0) begin
            errors++;
            $display("FAIL reset_mid: valids/readies %b cmd_ready %b awid %h want 000000 1 0",
                     {awvalid_o, wvalid_o, arvalid_o, bready_o, rready_o, rsp_valid_o}, cmd_ready_o, awid_o);
        end
        exp_id = 0;
        @(negedge clk); #1;
        areset = 1'b1;
        run_txn(1'b1, 32'd5, 32'h0BADF00D, 4'hF, 1, 0, 0, 0, 0, 2'b00, '0, "wr_after_reset");
        run_txn(1'b0, 32'd5, '0, '0, 0, 0, 0, 0, 1, 2'b00, '0, "rd_after_reset");
    endtask

    initial begin
        cmd_valid_i = 1'b0; cmd_write_i = 1'b0; cmd_addr_i = '0; cmd_wdata_i = '0; cmd_wstrb_i = '0;
        rsp_ready_i = 1'b0;
        aw_d = 0; w_d = 0; ar_d = 0; b_d = 0; r_d = 0; s_bresp = 2'b00; s_xor = '0;
        test_reset();
        test_write_read();
        test_errors();
        test_timeout();
        test_random();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule

// File: doc/axi_master_ctrl.md
Name: axi_master_ctrl

Overview:
- Single-outstanding AXI initiator that turns a simple command/response interface into single-beat AXI write and read transactions.
- It drives the s_axi_reg register file, or any slave with the same port set, from a local controller such as the counter control logic or a test sequencer.
- Handles independent AW/W handshakes, B/R response collection, ID tagging and checking, and a watchdog timeout.

Parameters:
- ADDR_W, 32, AXI address width
- DATA_W, 32, AXI data width (STRB_W = DATA_W/8)
- ID_W, 4, AXI transaction ID width
- TIMEOUT, 255, max cycles waiting on any slave handshake before abort; 0 disables the watchdog

Ports:
- clk  in  1  clock
- areset  in  1  asynchronous active-low reset
- cmd_valid_i  in  1  command request
- cmd_ready_o  out  1  command accepted when high with cmd_valid_i
- cmd_write_i  in  1  1=write, 0=read
- cmd_addr_i  in  ADDR_W  target address
- cmd_wdata_i  in  DATA_W  write data
- cmd_wstrb_i  in  STRB_W  write byte strobes
- rsp_valid_o  out  1  response available
- rsp_ready_i  in  1  response consumed
- rsp_rdata_o  out  DATA_W  read data (0 for writes)
- rsp_status_o  out  2  00 OK, 01 slave error (bresp!=0), 10 ID mismatch, 11 timeout
- awid_o, awaddr_o, awvalid_o / awready_i  AW channel (ID_W, ADDR_W, 1 / 1)
- wid_o, wdata_o, wstrb_o, wlast_o, wvalid_o / wready_i  W channel (wlast_o tied 1)
- bid_i, bresp_i, bvalid_i  in  ID_W, 2, 1  B channel; bready_o out 1
- arid_o, araddr_o, arvalid_o / arready_i  AR channel
- rid_i, rdata_i, rstrb_i, rlast_i, rvalid_i  in  R channel; rready_o out 1

Behaviour:
- Reset (async assert, sync release): state=IDLE, all *valid_o=0, bready_o=rready_o=0, cmd_ready_o=1, rsp_valid_o=0, rsp_rdata_o=0, rsp_status_o=00, ID counter=0, all address/data outputs=0.
- States: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA, RSP.
- IDLE:
  - cmd_ready_o=1. On cmd_valid_i&cmd_ready_o, the command is registered.
  - Next state is WR_REQ or RD_REQ.
  - The relevant valids assert in the next cycle; latency from command to valid is 1 cycle.
- WR_REQ:
  - awvalid_o and wvalid_o assert together.
  - Each channel deasserts individually the cycle after its own handshake. Simultaneous or either-order handshakes are all legal.
  - Move to WR_RESP once both channels have handshaked. bready_o=1 from the cycle of entry.
- WR_RESP:
  - On bvalid_i&bready_o, capture status: bid_i!=awid_o gives 10; else bresp_i!=0 gives 01; else 00.
  - bready_o drops, go to RSP.
- RD_REQ: arvalid_o=1 until arready_i, then RD_DATA with rready_o=1.
- RD_DATA:
  - On rvalid_i&rready_o, capture rdata_i. Status is 10 if rid_i!=arid_o, else 00.
  - rready_o drops, go to RSP.
  - rlast_i and rstrb_i are ignored; single beat only.
- RSP:
  - rsp_valid_o=1, held with stable data until rsp_ready_i.
  - Then IDLE, and the ID counter increments, wrapping at 2^ID_W-1 to 0.
  - cmd_ready_o=0 in all states except IDLE.
- Valid stability: once asserted, a valid and its payload stay stable until handshake (AXI rule). The only exception is the watchdog abort.
- Watchdog:
  - The counter resets on entry to each wait state and on every handshake.
  - If it reaches TIMEOUT, all valids and readies are forced to 0 and the block goes to RSP with status 11.
  - A late B or R beat arriving after the abort is ignored, because bready_o/rready_o are 0.
- Reset mid-transaction: everything returns to reset values immediately and the pending command is lost.
- One outstanding transaction at a time; no pipelining or bursts.

Decomposition:
- Package axi_pkg holds:
  - the state enum axi_m_state_t
  - status constants RSP_OK, RSP_SLVERR, RSP_IDERR, RSP_TIMEOUT
  - AXI response encodings OKAY=2'b00, SLVERR=2'b10
- One sub-module, axi_watchdog, contains the timeout counter, with clear and enable inputs and an expired output.

Test Plan:
- Write 0xDEADBEEF, strb 4'hF, to addr 3 with a slave that is always ready and returns bresp=00 → awvalid/wvalid asserted 1 cycle after the command, rsp_valid_o with status 00, awid_o=0.
- Write with awready_i immediate and wready_i delayed 3 cycles → awvalid_o drops after 1 cycle, wvalid_o held 4 cycles with stable wdata, bready_o high only after both handshakes.
- Read addr 3 after the write, with the slave returning rdata=0xDEADBEEF and rid=1 → rsp_rdata_o=0xDEADBEEF, status 00, arid_o=1.
- Read where the slave returns rid=5 while arid_o=2 → status 10. Write with bresp=2'b10 → status 01.
- Set TIMEOUT=8 and never assert arready_i → arvalid_o drops after 8 cycles, status 11, cmd_ready_o=1 once rsp_ready_i is given.
- Assert areset low while in WR_REQ → all valids 0 immediately; after release a new command completes normally with ID 0.
